// File: rtl/lsu_dmem_if.sv
// rtl/lsu_dmem_if.sv - core-side request/response and data-SRAM bus bundle for lsu_dmem
interface lsu_dmem_if #(
  parameter int DEPTH_WORDS = 2048
);
  localparam int AW = $clog2(DEPTH_WORDS);

  // Core request side
  logic          i_req;
  logic          mem_wren;
  logic [1:0]    i_data_type;
  logic          i_unsigned;
  logic [31:0]   i_addr;
  logic [31:0]   i_st_data;
  // Core response side
  logic          o_stall;
  logic          o_ld_vld;
  logic [31:0]   o_ld_data;
  // Data SRAM side
  logic          o_dmem_en;
  logic          o_dmem_we;
  logic [AW-1:0] o_dmem_addr;
  logic [31:0]   o_dmem_wdata;
  logic [3:0]    o_dmem_bmask;
  logic [31:0]   i_dmem_rdata;

  // The LSU itself
  modport slave (
    input  i_req, mem_wren, i_data_type, i_unsigned, i_addr, i_st_data, i_dmem_rdata,
    output o_stall, o_ld_vld, o_ld_data, o_dmem_en, o_dmem_we, o_dmem_addr,
           o_dmem_wdata, o_dmem_bmask
  );

  // The core plus SRAM environment around the LSU
  modport master (
    output i_req, mem_wren, i_data_type, i_unsigned, i_addr, i_st_data, i_dmem_rdata,
    input  o_stall, o_ld_vld, o_ld_data, o_dmem_en, o_dmem_we, o_dmem_addr,
           o_dmem_wdata, o_dmem_bmask
  );
endinterface

// File: rtl/lsu_dmem.sv
// rtl/lsu_dmem.sv - load/store unit driving a word-wide synchronous data SRAM, splitting misaligned accesses
module lsu_dmem #(
  parameter int DEPTH_WORDS = 2048
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  lsu_dmem_if.slave    bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, RD1, RD2, WR2} state_t;

  state_t        state_q;
  logic          wren_q;
  logic [1:0]    type_q;
  logic          uns_q;
  logic [1:0]    off_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   st_q;
  logic          mis_q;
  logic [31:0]   low_q;

  // Byte-lane mask of an access of the given type, anchored at lane 0
  function automatic logic [3:0] size_mask(input logic [1:0] t);
    case (t)
      2'b10:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Access crosses a word boundary (byte never does; half only at offset 3)
  function automatic logic misaligned(input logic [1:0] t, input logic [1:0] off);
    case (t)
      2'b10:   misaligned = 1'b0;
      2'b01:   misaligned = (off == 2'd3);
      default: misaligned = (off != 2'd0);
    endcase
  endfunction

  // Keep size bytes of an LSB-aligned value and zero/sign extend them
  function automatic logic [31:0] fmt_load(input logic [31:0] raw, input logic [1:0] t,
                                           input logic u);
    case (t)
      2'b10:   fmt_load = u ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   fmt_load = u ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: fmt_load = raw;
    endcase
  endfunction

  logic [1:0]    in_off;
  logic [AW-1:0] in_idx;
  logic          in_mis;
  logic [7:0]    in_mask8;
  logic [AW-1:0] nxt_idx;
  logic [2:0]    hi_n;
  logic [5:0]    hi_sh;
  logic          unused_addr;

  assign in_off      = bus.i_addr[1:0];
  assign in_idx      = bus.i_addr[AW+1:2];
  assign in_mis      = misaligned(bus.i_data_type, in_off);
  assign in_mask8    = {4'b0000, size_mask(bus.i_data_type)} << in_off;
  // Second word of a split access; wraps from the last word back to 0
  assign nxt_idx     = idx_q + AW'(1);
  // Number of bytes of the access that land in the first word, and that count in bits
  assign hi_n        = 3'd4 - {1'b0, off_q};
  assign hi_sh       = {hi_n, 3'b000};
  assign unused_addr = ^bus.i_addr[31:AW+2];

  logic          stall, ld_vld, en, we;
  logic [31:0]   ld_data, wdata;
  logic [AW-1:0] addr;
  logic [3:0]    bmask;

  // Per-state SRAM command and core response; first access is issued in the request cycle
  always_comb begin
    stall   = 1'b0;
    ld_vld  = 1'b0;
    ld_data = '0;
    en      = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    bmask   = '0;
    case (state_q)
      IDLE: begin
        if (bus.i_req) begin
          en   = 1'b1;
          addr = in_idx;
          if (bus.mem_wren) begin
            we    = 1'b1;
            wdata = bus.i_st_data << {in_off, 3'b000};
            bmask = in_mask8[3:0];
            stall = in_mis;
          end else begin
            stall = 1'b1;
          end
        end
      end
      WR2: begin
        en    = 1'b1;
        we    = 1'b1;
        addr  = nxt_idx;
        wdata = st_q >> hi_sh;
        bmask = size_mask(type_q) >> hi_n;
      end
      RD1: begin
        if (mis_q) begin
          en    = 1'b1;
          addr  = nxt_idx;
          stall = 1'b1;
        end else begin
          ld_vld  = 1'b1;
          ld_data = fmt_load(bus.i_dmem_rdata >> {off_q, 3'b000}, type_q, uns_q);
        end
      end
      RD2: begin
        ld_vld  = 1'b1;
        ld_data = fmt_load(low_q | (bus.i_dmem_rdata << hi_sh), type_q, uns_q);
      end
      default: ;
    endcase
  end

  // Reset forces every output low at once, including the combinational request-cycle issue
  assign bus.o_stall      = i_rst_n & stall;
  assign bus.o_ld_vld     = i_rst_n & ld_vld;
  assign bus.o_ld_data    = i_rst_n ? ld_data : '0;
  assign bus.o_dmem_en    = i_rst_n & en;
  assign bus.o_dmem_we    = i_rst_n & we;
  assign bus.o_dmem_addr  = i_rst_n ? addr : '0;
  assign bus.o_dmem_wdata = i_rst_n ? wdata : '0;
  assign bus.o_dmem_bmask = i_rst_n ? bmask : '0;

  // Sequencer: latch the request in IDLE, walk the split-access states, keep the low load half
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      wren_q  <= 1'b0;
      type_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      idx_q   <= '0;
      st_q    <= '0;
      mis_q   <= 1'b0;
      low_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_req) begin
            wren_q <= bus.mem_wren;
            type_q <= bus.i_data_type;
            uns_q  <= bus.i_unsigned;
            off_q  <= in_off;
            idx_q  <= in_idx;
            st_q   <= bus.i_st_data;
            mis_q  <= in_mis;
            if (!bus.mem_wren)  state_q <= RD1;
            else if (in_mis)    state_q <= WR2;
          end
        end
        RD1: begin
          if (mis_q) begin
            low_q   <= bus.i_dmem_rdata >> {off_q, 3'b000};
            state_q <= RD2;
          end else begin
            state_q <= IDLE;
          end
        end
        RD2:     state_q <= IDLE;
        WR2:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_dmem.sv
// tb/tb_lsu_dmem.sv - randomized self-checking bench for lsu_dmem against a byte-addressed memory model
module tb_lsu_dmem;
  localparam int DEPTH = 2048;
  localparam int NBYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_dmem_if #(.DEPTH_WORDS(DEPTH)) bus ();

  lsu_dmem #(.DEPTH_WORDS(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] init_word(input int w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Data SRAM: byte-enabled write, registered read
  logic [31:0] sram [DEPTH];
  initial begin
    for (int w = 0; w < DEPTH; w++) sram[w] = init_word(w);
    bus.i_dmem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.o_dmem_en) begin
        if (bus.o_dmem_we) begin
          for (int b = 0; b < 4; b++)
            if (bus.o_dmem_bmask[b]) sram[bus.o_dmem_addr][8*b +: 8] = bus.o_dmem_wdata[8*b +: 8];
        end else begin
          bus.i_dmem_rdata <= sram[bus.o_dmem_addr];
        end
      end
    end
  end

  // Reference model: flat byte memory, address taken modulo its size
  logic [7:0] ref_mem [NBYTES];

  function automatic int size_of(input logic [1:0] t);
    return (t == 2'b10) ? 1 : (t == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] t, input logic u);
    int sz = size_of(t);
    logic [31:0] v = 0;
    logic [31:0] ba;
    for (int k = 0; k < sz; k++) begin
      ba = a + k;
      v[8*k +: 8] = ref_mem[ba[12:0]];
    end
    if (!u && v[8*sz-1]) for (int k = 8*sz; k < 32; k++) v[k] = 1'b1;
    return v;
  endfunction

  logic        c_en [4];
  logic        c_we [4];
  logic [10:0] c_addr [4];
  logic [3:0]  c_bm [4];
  logic [31:0] c_wd [4];
  logic        stall_log [$];

  // Issue one request at posedge+1, hold it until stall drops, then check against the model
  task automatic run_op(input logic wr, input logic [1:0] t, input logic u, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] got, output int vcnt);
    int sz, off, exp_stall, exp_en, stalls, en_cnt, vld_cyc, bad_zero, cyc;
    logic mis, done;
    logic [31:0] ba, exp;
    sz = size_of(t);
    off = int'(a[1:0]);
    mis = (off + sz) > 4;
    exp_stall = wr ? (mis ? 1 : 0) : (mis ? 2 : 1);
    exp_en = mis ? 2 : 1;
    bus.i_req = 1'b1; bus.mem_wren = wr; bus.i_data_type = t;
    bus.i_unsigned = u; bus.i_addr = a; bus.i_st_data = d;
    stalls = 0; en_cnt = 0; vcnt = 0; vld_cyc = -1; bad_zero = 0; cyc = 0; got = '0; done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_en[i] = 0; c_we[i] = 0; c_addr[i] = 0; c_bm[i] = 0; c_wd[i] = 0;
    end
    while (!done) begin
      @(negedge clk);
      if (cyc < 4) begin
        c_en[cyc] = bus.o_dmem_en; c_we[cyc] = bus.o_dmem_we; c_addr[cyc] = bus.o_dmem_addr;
        c_bm[cyc] = bus.o_dmem_bmask; c_wd[cyc] = bus.o_dmem_wdata;
      end
      stall_log.push_back(bus.o_stall);
      if (bus.o_dmem_en) en_cnt++;
      if (bus.o_ld_vld) begin vcnt++; got = bus.o_ld_data; vld_cyc = cyc; end
      else if (bus.o_ld_data != 0) bad_zero++;
      if (bus.o_stall) stalls++; else done = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (!done && cyc > 6) begin
        check("timeout", 32'(cyc), 32'(exp_stall + 1));
        done = 1'b1;
      end
    end
    bus.i_req = 1'b0;
    check("stall_cycles", 32'(stalls), 32'(exp_stall));
    check("en_cycles", 32'(en_cnt), 32'(exp_en));
    check("ld_data_zero", 32'(bad_zero), 32'd0);
    if (wr) begin
      check("st_no_vld", 32'(vcnt), 32'd0);
      for (int k = 0; k < sz; k++) begin
        ba = a + k;
        ref_mem[ba[12:0]] = d[8*k +: 8];
      end
    end else begin
      exp = exp_load(a, t, u);
      check("ld_vld_count", 32'(vcnt), 32'd1);
      check("ld_vld_cycle", 32'(vld_cyc), 32'(exp_stall));
      check("ld_data", got, exp);
    end
  endtask

  logic [31:0] got;
  int vcnt, vtot, any, mism;
  logic [3:0] pat;

  initial begin
    for (int w = 0; w < DEPTH; w++) begin
      logic [31:0] iw;
      iw = init_word(w);
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = iw[8*b +: 8];
    end
    rst_n = 1'b0;
    bus.i_req = 0; bus.mem_wren = 0; bus.i_data_type = 0; bus.i_unsigned = 0;
    bus.i_addr = 0; bus.i_st_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    any = int'(bus.o_stall | bus.o_ld_vld | bus.o_dmem_en | bus.o_dmem_we) + int'(|bus.o_ld_data)
        + int'(|bus.o_dmem_addr) + int'(|bus.o_dmem_wdata) + int'(|bus.o_dmem_bmask);
    check("reset_outputs", 32'(any), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned word store then load
    run_op(1, 2'b00, 0, 32'h10, 32'h8899AABB, got, vcnt);
    check("sw_en", 32'(c_en[0]), 32'd1);
    check("sw_we", 32'(c_we[0]), 32'd1);
    check("sw_addr", 32'(c_addr[0]), 32'd4);
    check("sw_bmask", 32'(c_bm[0]), 32'hF);
    check("sw_wdata", c_wd[0], 32'h8899AABB);
    run_op(0, 2'b00, 0, 32'h10, 0, got, vcnt);
    check("lw_const", got, 32'h8899AABB);

    // Sub-word extension
    run_op(0, 2'b10, 0, 32'h12, 0, got, vcnt); check("lb", got, 32'hFFFFFF99);
    run_op(0, 2'b10, 1, 32'h12, 0, got, vcnt); check("lbu", got, 32'h00000099);
    run_op(0, 2'b01, 0, 32'h12, 0, got, vcnt); check("lh", got, 32'hFFFF8899);
    run_op(0, 2'b01, 1, 32'h10, 0, got, vcnt); check("lhu", got, 32'h0000AABB);
    run_op(1, 2'b10, 0, 32'h11, 32'h000000CC, got, vcnt);
    check("sb_bmask", 32'(c_bm[0]), 32'h2);
    check("sb_wdata", c_wd[0], 32'h0000CC00);
    run_op(0, 2'b00, 0, 32'h10, 0, got, vcnt); check("sb_readback", got, 32'h8899CCBB);

    // Misaligned word store and load
    run_op(1, 2'b00, 0, 32'h13, 32'h11223344, got, vcnt);
    check("msw_addr0", 32'(c_addr[0]), 32'd4);
    check("msw_bm0", 32'(c_bm[0]), 32'h8);
    check("msw_wd0", c_wd[0], 32'h44000000);
    check("msw_addr1", 32'(c_addr[1]), 32'd5);
    check("msw_bm1", 32'(c_bm[1]), 32'h7);
    check("msw_wd1", c_wd[1], 32'h00112233);
    run_op(0, 2'b00, 0, 32'h13, 0, got, vcnt); check("mlw", got, 32'h11223344);

    // Wrap from the last word to word 0
    run_op(1, 2'b00, 0, 32'h1FFC, 32'hAB000000, got, vcnt);
    run_op(1, 2'b00, 0, 32'h0000, 32'h000000CD, got, vcnt);
    run_op(0, 2'b01, 0, 32'h1FFF, 0, got, vcnt);
    check("wrap_addr0", 32'(c_addr[0]), 32'd2047);
    check("wrap_addr1", 32'(c_addr[1]), 32'd0);
    check("wrap_data", got, 32'hFFFFCDAB);

    // Back-to-back: SW, LW, SB with no idle cycle between them
    stall_log.delete();
    vtot = 0;
    run_op(1, 2'b00, 0, 32'h20, 32'h55667788, got, vcnt); vtot += vcnt;
    run_op(0, 2'b00, 0, 32'h20, 0, got, vcnt);            vtot += vcnt;
    check("b2b_lw", got, 32'h55667788);
    run_op(1, 2'b10, 0, 32'h24, 32'h0000005A, got, vcnt); vtot += vcnt;
    pat = {stall_log[0], stall_log[1], stall_log[2], stall_log[3]};
    check("b2b_stall_pattern", 32'(pat), 32'b0100);
    check("b2b_cycles", 32'(stall_log.size()), 32'd4);
    check("b2b_vld_total", 32'(vtot), 32'd1);

    // Reset during RD1 of a misaligned load
    bus.i_req = 1; bus.mem_wren = 0; bus.i_data_type = 2'b00; bus.i_unsigned = 0;
    bus.i_addr = 32'h13; bus.i_st_data = 0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    any = int'(bus.o_stall | bus.o_ld_vld | bus.o_dmem_en | bus.o_dmem_we) + int'(|bus.o_ld_data)
        + int'(|bus.o_dmem_addr) + int'(|bus.o_dmem_wdata) + int'(|bus.o_dmem_bmask);
    check("midop_reset_outputs", 32'(any), 32'd0);
    bus.i_req = 0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    vtot = 0; any = 0;
    repeat (3) begin
      @(negedge clk);
      vtot += int'(bus.o_ld_vld);
      any += int'(bus.o_stall | bus.o_dmem_en);
    end
    check("post_reset_no_vld", 32'(vtot), 32'd0);
    check("post_reset_idle", 32'(any), 32'd0);
    @(posedge clk); #1;
    run_op(0, 2'b00, 0, 32'h13, 0, got, vcnt); check("post_reset_mlw", got, 32'h11223344);

    // Randomized traffic, some of it pinned to the wrap boundary
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [1:0] t;
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = {a[31:13], 11'h7FF, a[1:0]};
      else if ($urandom_range(0, 7) == 0) a = {a[31:13], 11'h000, a[1:0]};
      t = 2'($urandom_range(0, 3));
      run_op(1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 1)), a, $urandom, got, vcnt);
    end

    mism = 0;
    for (int w = 0; w < DEPTH; w++)
      if (sram[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) mism++;
    check("final_memory", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
